// File: rtl/mips_pipe_pkg.sv
// Shared types and helpers for the MIPS pipeline-register chain and the hazard unit.
package mips_pipe_pkg;

  localparam int REG_AW_DEF = 5;
  localparam logic [REG_AW_DEF-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic [REG_AW_DEF-1:0] dest;
    logic [63:0]           data;
  } slot_t;

  // Width of a forwarding selector: 0 = register file, 1..depth = slot index + 1.
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mips_pipe_slot.sv
// One pipeline slot register {valid, wb_en, dest, data} with load / hold / bubble control.
module mips_pipe_slot #(
  parameter int WIDTH  = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              bubble_i,
  input  logic              valid_i,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] dest_i,
  input  logic [WIDTH-1:0]  data_i,
  output logic              valid_o,
  output logic              wb_en_o,
  output logic [REG_AW-1:0] dest_o,
  output logic [WIDTH-1:0]  data_o
);

  logic              valid_q, valid_d;
  logic              wb_en_q, wb_en_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic [WIDTH-1:0]  data_q, data_d;

  // Bubble has priority over load; neither means hold.
  always_comb begin
    valid_d = valid_q;
    wb_en_d = wb_en_q;
    dest_d  = dest_q;
    data_d  = data_q;
    if (bubble_i) begin
      valid_d = 1'b0;
      wb_en_d = 1'b0;
      dest_d  = '0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = valid_i;
      wb_en_d = wb_en_i & valid_i;
      dest_d  = dest_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      wb_en_q <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      wb_en_q <= wb_en_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign wb_en_o = wb_en_q;
  assign dest_o  = dest_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mips_pipe_chain.sv
// Parametrised IF/ID..MEM/WB register chain with stall bubbles, branch flush and stall counter.
// Optional forwarding-source selection is built when MIPS_PIPE_FWD_EN is defined.
module mips_pipe_chain
  import mips_pipe_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int WIDTH       = 64,
  parameter int REG_AW      = REG_AW_DEF,
  parameter int STALL_AT    = 1,
  parameter int FLUSH_SLOTS = 2,
  parameter int SELW        = sel_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_wb_en,
  input  logic [REG_AW-1:0]      in_dest,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic                   stall_req,
  input  logic                   flush,
  output logic [DEPTH-1:0]       slot_valid,
  output logic [DEPTH*WIDTH-1:0] slot_data,
  output logic                   out_valid,
  output logic                   out_wb_en,
  output logic [REG_AW-1:0]      out_dest,
  input  logic [REG_AW-1:0]      rs_a,
  input  logic [REG_AW-1:0]      rs_b,
  output logic [SELW-1:0]        fwd_sel_a,
  output logic [SELW-1:0]        fwd_sel_b,
  output logic [15:0]            stall_cycles
);

  logic              stall_eff;
  logic [DEPTH-1:0]  load, bubble;
  logic [DEPTH-1:0]  v, wb;
  logic [REG_AW-1:0] dst [DEPTH];
  logic [WIDTH-1:0]  dat [DEPTH];
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  // Flush overrides stall, so a simultaneous stall is neither applied nor counted.
  assign stall_eff = stall_req & ~flush;
  assign in_ready  = ~stall_eff;

  always_comb begin
    load   = '1;
    bubble = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (flush) begin
        bubble[k] = (k < FLUSH_SLOTS);
      end else if (stall_eff) begin
        if (k < STALL_AT) load[k] = 1'b0;
        else if (k == STALL_AT) bubble[k] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic              d_valid, d_wb_en;
    logic [REG_AW-1:0] d_dest;
    logic [WIDTH-1:0]  d_data;

    if (k == 0) begin : g_head
      // An invalid offer enters as an all-zero bubble.
      assign d_valid = in_valid;
      assign d_wb_en = in_wb_en & in_valid;
      assign d_dest  = in_valid ? in_dest : '0;
      assign d_data  = in_valid ? in_data : '0;
    end else begin : g_body
      assign d_valid = v[k-1];
      assign d_wb_en = wb[k-1];
      assign d_dest  = dst[k-1];
      assign d_data  = dat[k-1];
    end

    mips_pipe_slot #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load[k]),
      .bubble_i (bubble[k]),
      .valid_i  (d_valid),
      .wb_en_i  (d_wb_en),
      .dest_i   (d_dest),
      .data_i   (d_data),
      .valid_o  (v[k]),
      .wb_en_o  (wb[k]),
      .dest_o   (dst[k]),
      .data_o   (dat[k])
    );

    assign slot_data[k*WIDTH +: WIDTH] = dat[k];
  end

  assign slot_valid = v;
  assign out_valid  = v[DEPTH-1];
  assign out_wb_en  = wb[DEPTH-1] & v[DEPTH-1];
  assign out_dest   = dst[DEPTH-1];

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_eff && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;

`ifdef MIPS_PIPE_FWD_EN
  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    for (int j = DEPTH - 1; j > STALL_AT; j--) begin
      if (v[j] && wb[j] && dst[j] == rs_a && rs_a != '0) fwd_sel_a = SELW'(j + 1);
      if (v[j] && wb[j] && dst[j] == rs_b && rs_b != '0) fwd_sel_b = SELW'(j + 1);
    end
  end
`else
  logic unused_rs;
  assign unused_rs = ^{rs_a, rs_b};
  assign fwd_sel_a = '0;
  assign fwd_sel_b = '0;
`endif

endmodule

// File: tb/tb_mips_pipe_chain.sv
// Self-checking bench for mips_pipe_chain: directed steps plus random traffic against a queue model.
module tb_mips_pipe_chain;

  localparam int D    = 4;
  localparam int W    = 64;
  localparam int AW   = 5;
  localparam int SA   = 1;
  localparam int FS   = 2;
  localparam int SELW = 3;

  typedef struct packed {
    logic          valid;
    logic          wb;
    logic [AW-1:0] dest;
    logic [W-1:0]  data;
  } ins_t;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_wb_en, stall_req, flush;
  logic [AW-1:0]   in_dest, rs_a, rs_b;
  logic [W-1:0]    in_data;
  logic            in_ready, out_valid, out_wb_en;
  logic [D-1:0]    slot_valid;
  logic [D*W-1:0]  slot_data;
  logic [AW-1:0]   out_dest;
  logic [SELW-1:0] fwd_sel_a, fwd_sel_b;
  logic [15:0]     stall_cycles;

  ins_t mq[$];
  int   m_cnt;
  int   n_chk;
  int   n_fail;

  always #5 clk = ~clk;

  mips_pipe_chain dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_wb_en(in_wb_en), .in_dest(in_dest), .in_data(in_data),
    .in_ready(in_ready), .stall_req(stall_req), .flush(flush),
    .slot_valid(slot_valid), .slot_data(slot_data),
    .out_valid(out_valid), .out_wb_en(out_wb_en), .out_dest(out_dest),
    .rs_a(rs_a), .rs_b(rs_b), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest slot past the stall point whose write matches the source register.
  function automatic logic [SELW-1:0] exp_fwd(input logic [AW-1:0] rs);
`ifdef MIPS_PIPE_FWD_EN
    for (int j = SA + 1; j < D; j++)
      if (mq[j].valid && mq[j].wb && mq[j].dest == rs && rs != 0) return SELW'(j + 1);
`endif
    return '0;
  endfunction

  // Queue view of the chain: advance = push a new head and retire the tail.
  task automatic model_tick();
    ins_t nw;
    if (rst) begin
      mq.delete();
      for (int i = 0; i < D; i++) mq.push_back('0);
      m_cnt = 0;
    end else if (flush) begin
      mq.push_front('0);
      void'(mq.pop_back());
      for (int i = 0; i < FS; i++) mq[i] = '0;
    end else if (stall_req) begin
      mq.insert(SA, '0);
      void'(mq.pop_back());
      if (m_cnt < 65535) m_cnt++;
    end else begin
      nw = '0;
      if (in_valid) begin
        nw.valid = 1'b1;
        nw.wb    = in_wb_en;
        nw.dest  = in_dest;
        nw.data  = in_data;
      end
      mq.push_front(nw);
      void'(mq.pop_back());
    end
  endtask

  task automatic check_state();
    logic [D-1:0]   ev;
    logic [D*W-1:0] ed;
    for (int k = 0; k < D; k++) begin
      ev[k]          = mq[k].valid;
      ed[k*W +: W]   = mq[k].data;
    end
    chk("slot_valid", 256'(slot_valid), 256'(ev));
    chk("slot_data", 256'(slot_data), 256'(ed));
    chk("out_valid", 256'(out_valid), 256'(mq[D-1].valid));
    chk("out_wb_en", 256'(out_wb_en), 256'(mq[D-1].wb & mq[D-1].valid));
    chk("out_dest", 256'(out_dest), 256'(mq[D-1].dest));
    chk("stall_cycles", 256'(stall_cycles), 256'(m_cnt));
  endtask

  // Inputs are driven just after a falling edge; combinational outputs checked before the rising edge.
  task automatic cycle();
    #1;
    if (!rst) begin
      chk("in_ready", 256'(in_ready), 256'(!(stall_req && !flush)));
      chk("fwd_sel_a", 256'(fwd_sel_a), 256'(exp_fwd(rs_a)));
      chk("fwd_sel_b", 256'(fwd_sel_b), 256'(exp_fwd(rs_b)));
    end
    @(posedge clk);
    model_tick();
    @(negedge clk);
    check_state();
  endtask

  task automatic offer(input logic v, input logic wbe, input logic [AW-1:0] dst, input logic [W-1:0] dt);
    in_valid = v; in_wb_en = wbe; in_dest = dst; in_data = dt;
    stall_req = 1'b0; flush = 1'b0;
    cycle();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; m_cnt = 0;
    for (int i = 0; i < D; i++) mq.push_back('0);
    rst = 1'b1; in_valid = 1'b0; in_wb_en = 1'b0; in_dest = '0; in_data = '0;
    stall_req = 1'b0; flush = 1'b0; rs_a = '0; rs_b = '0;
    @(negedge clk);
    cycle();
    chk("reset_valid", 256'(slot_valid), 256'(0));
    chk("reset_count", 256'(stall_cycles), 256'(0));
    rst = 1'b0;

    // Stream 1..6 then drain; first result appears after the 4th offer.
    for (int c = 1; c <= 9; c++) begin
      if (c <= 6) offer(1'b1, 1'b1, AW'(c), W'(c));
      else        offer(1'b0, 1'b0, '0, '0);
      if (c >= 4) begin
        chk("stream_out_valid", 256'(out_valid), 256'(1));
        chk("stream_out_data", 256'(slot_data[(D-1)*W +: W]), 256'(c - 3));
      end
    end

    // Single stall with a full chain of A,B,C,D.
    offer(1'b1, 1'b1, 5'd4, 64'hD); offer(1'b1, 1'b1, 5'd3, 64'hC);
    offer(1'b1, 1'b1, 5'd2, 64'hB); offer(1'b1, 1'b1, 5'd1, 64'hA);
    in_valid = 1'b1; in_data = 64'hEE; stall_req = 1'b1;
    #1 chk("stall_in_ready", 256'(in_ready), 256'(0));
    cycle();
    chk("stall_slots", 256'(slot_data), 256'({64'hC, 64'hB, 64'h0, 64'hA}));
    chk("stall_valid", 256'(slot_valid), 256'(4'b1101));
    chk("stall_count", 256'(stall_cycles), 256'(1));

    // Flush with a full chain.
    offer(1'b1, 1'b1, 5'd4, 64'h4); offer(1'b1, 1'b1, 5'd3, 64'h3);
    offer(1'b1, 1'b0, 5'd2, 64'h2); offer(1'b1, 1'b1, 5'd1, 64'h1);
    flush = 1'b1;
    cycle();
    chk("flush_valid", 256'(slot_valid), 256'(4'b1100));
    chk("flush_out_wb", 256'(out_wb_en), 256'(1));

    // Flush plus stall: flush only, counter unchanged.
    offer(1'b1, 1'b1, 5'd9, 64'h9);
    stall_req = 1'b1; flush = 1'b1;
    #1 chk("fs_in_ready", 256'(in_ready), 256'(1));
    cycle();
    chk("fs_count", 256'(stall_cycles), 256'(1));
    chk("fs_valid", 256'(slot_valid[1:0]), 256'(0));

    // Forwarding priority: youngest matching writer wins.
    offer(1'b1, 1'b1, 5'd7, 64'h71); offer(1'b1, 1'b1, 5'd7, 64'h72);
    offer(1'b1, 1'b1, 5'd1, 64'h73); offer(1'b1, 1'b1, 5'd2, 64'h74);
    rs_a = 5'd7; #1;
`ifdef MIPS_PIPE_FWD_EN
    chk("fwd_young", 256'(fwd_sel_a), 256'(3));
`else
    chk("fwd_off", 256'(fwd_sel_a), 256'(0));
`endif
    rs_a = 5'd0; #1 chk("fwd_zero_reg", 256'(fwd_sel_a), 256'(0));
    offer(1'b1, 1'b1, 5'd7, 64'h81); offer(1'b1, 1'b0, 5'd7, 64'h82);
    offer(1'b1, 1'b1, 5'd1, 64'h83); offer(1'b1, 1'b1, 5'd2, 64'h84);
    rs_a = 5'd7; #1;
`ifdef MIPS_PIPE_FWD_EN
    chk("fwd_skip_nowb", 256'(fwd_sel_a), 256'(4));
`else
    chk("fwd_off2", 256'(fwd_sel_a), 256'(0));
`endif

    // Random traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_wb_en  = $urandom_range(0, 1);
      in_dest   = AW'($urandom_range(0, 7));
      in_data   = {$urandom, $urandom};
      stall_req = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      rs_a      = AW'($urandom_range(0, 7));
      rs_b      = AW'($urandom_range(0, 7));
      cycle();
    end
    rst = 1'b0; flush = 1'b0;

    // Counter saturation over a long stall, then reset clears everything.
    offer(1'b1, 1'b1, 5'd3, 64'h55);
    stall_req = 1'b1;
    for (int n = 0; n < 70000; n++) begin
      @(posedge clk);
      model_tick();
    end
    @(negedge clk);
    chk("sat_count", 256'(stall_cycles), 256'(16'hFFFF));
    check_state();
    rst = 1'b1;
    cycle();
    chk("rst_count", 256'(stall_cycles), 256'(0));
    chk("rst_valid", 256'(slot_valid), 256'(0));
    rst = 1'b0; stall_req = 1'b0;
    offer(1'b0, 1'b0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
